display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_pkg.sv | 29 ++
 rtl/display_scan_ctrl_scan_timer.sv | 26 ++
 rtl/display_scan_ctrl.sv | 129 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants, scan-state type and address-decode helpers for the display scanner.
package display_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int SEG_W      = 8;
  localparam int DIG_W      = 3;

  // DISP_ADDRESS[6:4] codes that map onto a digit; 6 is the leftmost (index 0)
  localparam logic [2:0] DIG_ADDR_FIRST = 3'd1;
  localparam logic [2:0] DIG_ADDR_LAST  = 3'd6;

  typedef enum logic {
    LIT   = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  function automatic logic addr_is_digit(input logic [2:0] code);
    return (code >= DIG_ADDR_FIRST) && (code <= DIG_ADDR_LAST);
  endfunction

  function automatic logic [DIG_W-1:0] addr_to_digit(input logic [2:0] code);
    return DIG_ADDR_LAST - code;
  endfunction

  function automatic logic [DIG_W-1:0] next_digit(input logic [DIG_W-1:0] d);
    return (d == DIG_W'(NUM_DIGITS - 1)) ? '0 : d + DIG_W'(1);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_timer.sv
// Prescaler for the display scanner: counts up from 0 and pulses done on the
// last cycle of a state whose length is load_val, then restarts from 0.
module scan_timer #(
  parameter int TW = 4
) (
  input  logic          Clock,
  input  logic          Reset_n,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] count_reg;
  logic [TW-1:0] count_plus;

  assign count_plus = count_reg + TW'(1);
  assign done       = (count_plus == load_val);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= done ? '0 : count_plus;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Six-digit multiplexed 7-segment scanner with CPU bit-addressable segment storage.
// Optional macro DISP_READBACK_EN adds the Data_Out readback port.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  CE_DISPLAY,
  input  logic [6:0]            DISP_ADDRESS,
  input  logic                  Write,
  input  logic [7:0]            Data_In,
  output logic [NUM_DIGITS-1:0] Digit_Sel,
  output logic [SEG_W-1:0]      Segments
`ifdef DISP_READBACK_EN
  ,
  output logic [7:0]            Data_Out
`endif
);

  localparam int MAX_LEN = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int TW      = $clog2(MAX_LEN + 1);

  logic [SEG_W-1:0]      seg_mem_reg [NUM_DIGITS];
  logic                  ce_prev_reg;
  logic                  addr_valid;
  logic [DIG_W-1:0]      addr_digit;
  logic [2:0]            addr_bit;
  logic                  wr_en;

  scan_state_t           state_reg, state_next;
  logic [DIG_W-1:0]      digit_reg, digit_next;
  logic [TW-1:0]         load_val;
  logic                  tmr_done;
  logic [NUM_DIGITS-1:0] dsel_reg, dsel_next;
  logic [SEG_W-1:0]      seg_reg, seg_next;

  assign addr_valid = addr_is_digit(DISP_ADDRESS[6:4]);
  assign addr_digit = addr_to_digit(DISP_ADDRESS[6:4]);
  assign addr_bit   = DISP_ADDRESS[2:0];
  // Only the first clock of a CE_DISPLAY-high run writes
  assign wr_en      = CE_DISPLAY && Write && !ce_prev_reg && addr_valid;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ce_prev_reg <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        seg_mem_reg[i] <= '0;
      end
    end else begin
      ce_prev_reg <= CE_DISPLAY;
      if (wr_en) begin
        seg_mem_reg[addr_digit][addr_bit] <= Data_In[0];
      end
    end
  end

  assign load_val = (state_reg == LIT) ? TW'(CLK_DIV) : TW'(BLANK_CYCLES);

  scan_timer #(.TW(TW)) u_timer (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .load_val (load_val),
    .done     (tmr_done)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= LIT;
      digit_reg <= '0;
    end else begin
      state_reg <= state_next;
      digit_reg <= digit_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    digit_next = digit_reg;
    if (tmr_done) begin
      case (state_reg)
        LIT: begin
          if (BLANK_CYCLES == 0) begin
            digit_next = next_digit(digit_reg);
          end else begin
            state_next = BLANK;
          end
        end
        BLANK: begin
          state_next = LIT;
          digit_next = next_digit(digit_reg);
        end
        default: state_next = LIT;
      endcase
    end
  end

  // Outputs follow the next state so the drive lines up with the state register;
  // segment data comes from pre-write storage, so writes show one cycle later.
  always_comb begin
    dsel_next = '0;
    seg_next  = '0;
    if (state_next == LIT) begin
      dsel_next = NUM_DIGITS'(1) << digit_next;
      seg_next  = seg_mem_reg[digit_next];
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      dsel_reg <= NUM_DIGITS'(1);
      seg_reg  <= '0;
    end else begin
      dsel_reg <= dsel_next;
      seg_reg  <= seg_next;
    end
  end

  assign Digit_Sel = dsel_reg;
  assign Segments  = seg_reg;

`ifdef DISP_READBACK_EN
  assign Data_Out = (CE_DISPLAY && !Write && addr_valid)
                    ? {7'b0, seg_mem_reg[addr_digit][addr_bit]} : 8'h00;
`endif

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: table vectors, corner sequences and
// randomized traffic against a cycle-count based reference model.
module tb_display_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int BLANK_C = 2;
  localparam int SLOT    = CLK_DIV + BLANK_C;
  localparam int PERIOD  = 6 * SLOT;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       CE_DISPLAY = 1'b0;
  logic [6:0] DISP_ADDRESS = '0;
  logic       Write = 1'b0;
  logic [7:0] Data_In = '0;
  logic [5:0] Digit_Sel;
  logic [7:0] Segments;
`ifdef DISP_READBACK_EN
  logic [7:0] Data_Out;
`endif

  int tests = 0;
  int fails = 0;

  display_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_C)) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .CE_DISPLAY   (CE_DISPLAY),
    .DISP_ADDRESS (DISP_ADDRESS),
    .Write        (Write),
    .Data_In      (Data_In),
    .Digit_Sel    (Digit_Sel),
    .Segments     (Segments)
`ifdef DISP_READBACK_EN
    ,
    .Data_Out     (Data_Out)
`endif
  );

  always #5 Clock = ~Clock;

  // Reference model: storage, what the display shows (storage one edge ago),
  // CE history and edges since reset.
  logic [7:0] m_mem   [6];
  logic [7:0] m_shown [6];
  bit         m_ce_prev;
  int         m_t;

  function automatic void model_reset();
    for (int i = 0; i < 6; i++) begin
      m_mem[i]   = '0;
      m_shown[i] = '0;
    end
    m_ce_prev = 1'b1;
    m_t       = 0;
  endfunction

  function automatic void model_edge(input bit ce, input bit wr, input logic [6:0] addr, input bit d);
    int code;
    for (int i = 0; i < 6; i++) m_shown[i] = m_mem[i];
    code = int'(addr[6:4]);
    if (ce && wr && !m_ce_prev && code >= 1 && code <= 6) m_mem[6 - code][addr[2:0]] = d;
    m_ce_prev = ce;
    m_t++;
  endfunction

  function automatic bit model_lit();
    return ((m_t % PERIOD) % SLOT) < CLK_DIV;
  endfunction

  function automatic int model_digit();
    return (m_t % PERIOD) / SLOT;
  endfunction

  function automatic logic [5:0] exp_dsel();
    return model_lit() ? 6'(1 << model_digit()) : 6'h00;
  endfunction

  function automatic logic [7:0] exp_seg();
    return model_lit() ? m_shown[model_digit()] : 8'h00;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0d got=%h expected=%h", name, m_t, act, exp);
    end
  endtask

  task automatic model_check();
    check("scan_dsel", {2'b00, Digit_Sel}, {2'b00, exp_dsel()});
    check("scan_seg", Segments, exp_seg());
  endtask

  // Drive at the falling edge, update model at the rising edge, compare at the next falling edge
  task automatic step(input bit ce, input bit wr, input logic [6:0] addr, input bit d);
    CE_DISPLAY   = ce;
    Write        = wr;
    DISP_ADDRESS = addr;
    Data_In      = {7'($urandom_range(0, 127)), d};
    @(posedge Clock);
    model_edge(ce, wr, addr, d);
    @(negedge Clock);
    model_check();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 7'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset_n = 1'b0;
    CE_DISPLAY = 1'b0; Write = 1'b0; DISP_ADDRESS = '0; Data_In = '0;
    #2;
    Reset_n = 1'b1;
    model_reset();
    model_check();
  endtask

  task automatic wait_lit(input int dig);
    int k;
    for (k = 0; k < 2 * PERIOD; k++) begin
      if (model_lit() && model_digit() == dig) break;
      idle();
    end
    if (k == 2 * PERIOD) begin
      tests++; fails++;
      $display("FAIL wait_lit digit=%0d never lit within budget", dig);
    end
  endtask

  typedef struct {
    logic [6:0] addr;
    bit         data;
    int         dig;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int lit_len;

    vecs[0]  = '{7'h67, 1'b1, 0, 8'h80};
    vecs[1]  = '{7'h10, 1'b1, 5, 8'h01};
    vecs[2]  = '{7'h35, 1'b1, 3, 8'h20};
    vecs[3]  = '{7'h3F, 1'b1, 3, 8'hA0};
    vecs[4]  = '{7'h35, 1'b0, 3, 8'h80};
    vecs[5]  = '{7'h03, 1'b1, 0, 8'h80};
    vecs[6]  = '{7'h73, 1'b1, 5, 8'h01};
    vecs[7]  = '{7'h4A, 1'b1, 2, 8'h04};
    vecs[8]  = '{7'h21, 1'b1, 4, 8'h02};
    vecs[9]  = '{7'h5F, 1'b1, 1, 8'h80};
    vecs[10] = '{7'h5E, 1'b1, 1, 8'hC0};
    vecs[11] = '{7'h67, 1'b0, 0, 8'h00};

    // Reset state
    do_reset();
    check("rst_dsel", {2'b00, Digit_Sel}, 8'h01);
    check("rst_seg", Segments, 8'h00);

    // Table vectors: each write, then observe the target digit when lit
    for (int v = 0; v < 12; v++) begin
      idle();
      step(1'b1, 1'b1, vecs[v].addr, vecs[v].data);
      idle();
      wait_lit(vecs[v].dig);
      check("vec", Segments, vecs[v].exp_byte);
    end

    // Held CE/Write: one write with the first-cycle data
    do_reset();
    idle();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 7'h10, (i % 2) == 0);
    idle();
    wait_lit(5);
    check("hold_once", Segments, 8'h01);

    // Out-of-range digit codes change nothing over a full scan
    do_reset();
    idle();
    step(1'b1, 1'b1, 7'h03, 1'b1);
    idle();
    step(1'b1, 1'b1, 7'h73, 1'b1);
    for (int i = 0; i < PERIOD; i++) begin
      idle();
      check("ignored_seg", Segments, 8'h00);
    end

    // Scan sequence landmarks
    do_reset();
    for (int i = 1; i <= PERIOD; i++) begin
      idle();
      if (i == 4)  check("seq_blank0", {2'b00, Digit_Sel}, 8'h00);
      if (i == 6)  check("seq_dig1", {2'b00, Digit_Sel}, 8'h02);
      if (i == 30) check("seq_dig5", {2'b00, Digit_Sel}, 8'h20);
      if (i == 35) check("seq_blank5", {2'b00, Digit_Sel}, 8'h00);
      if (i == 36) check("seq_wrap", {2'b00, Digit_Sel}, 8'h01);
    end

    // Write to the lit digit, then an asynchronous reset mid-LIT
    do_reset();
    idle();
    step(1'b1, 1'b1, 7'h60, 1'b1);
    check("live_wr_edge", Segments, 8'h00);
    idle();
    check("live_wr_next", Segments, 8'h01);
    while (m_t < 7) idle();
    check("pre_rst_dsel", {2'b00, Digit_Sel}, 8'h02);
    Reset_n = 1'b0;
    #1;
    check("async_rst_dsel", {2'b00, Digit_Sel}, 8'h01);
    check("async_rst_seg", Segments, 8'h00);
    #1;
    Reset_n = 1'b1;
    model_reset();
    model_check();
    lit_len = 1;
    for (int i = 0; i < 2 * CLK_DIV; i++) begin
      idle();
      if (Digit_Sel == 6'h01) lit_len++;
      else break;
    end
    check("lit_len", 8'(lit_len), 8'(CLK_DIV));

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
           7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
    end

`ifdef DISP_READBACK_EN
    do_reset();
    idle();
    step(1'b1, 1'b1, 7'h35, 1'b1);
    idle();
    CE_DISPLAY = 1'b1; Write = 1'b0; DISP_ADDRESS = 7'h35;
    #1;
    check("readback_set", Data_Out, 8'h01);
    DISP_ADDRESS = 7'h34;
    #1;
    check("readback_clr", Data_Out, 8'h00);
    CE_DISPLAY = 1'b0;
    #1;
    check("readback_idle", Data_Out, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
